// File: rtl/acia_fifo_if.sv
// CPU-side register bus of the FIFO-buffered ACIA.
// The master drives the select, strobe, address and write data.
// The slave returns the registered read data and the interrupt request.
interface acia_fifo_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (
    output cs, we, addr, din,
    input  dout, irq
  );

  modport slave (
    input  cs, we, addr, din,
    output dout, irq
  );
endinterface

// File: rtl/acia_fifo.sv
// FIFO-buffered ACIA: 8N1 serial transmitter and receiver.
// Each direction has its own FIFO, and both are reached through a 4-register CPU bus.
// Register map: 0 ctrl/status, 1 data, 2 RX level, 3 TX level.
module acia_fifo #(
  parameter int CLK_FREQ   = 32000000,
  parameter int SYM_RATE   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  acia_fifo_if.slave bus,
  input  logic       rx,
  output logic       tx
);
  localparam int SYM_CNT = CLK_FREQ / SYM_RATE;
  localparam int HALF    = (SYM_CNT / 2 > 0) ? SYM_CNT / 2 : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = (SYM_CNT > 1) ? $clog2(SYM_CNT) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(SYM_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------
  logic wr_ctrl, wr_data, rd_any, rd_status, rd_data;
  logic soft_rst, clr, rx_flush, tx_flush;

  assign wr_ctrl   = bus.cs &  bus.we & (bus.addr == 2'd0);
  assign wr_data   = bus.cs &  bus.we & (bus.addr == 2'd1);
  assign rd_any    = bus.cs & ~bus.we;
  assign rd_status = rd_any & (bus.addr == 2'd0);
  assign rd_data   = rd_any & (bus.addr == 2'd1);
  assign soft_rst  = wr_ctrl & (bus.din[1:0] == 2'b11);
  // The soft reset clears everything a hard reset does, except the interrupt enables.
  assign clr       = rst | soft_rst;
  assign rx_flush  = wr_ctrl & bus.din[2];
  assign tx_flush  = wr_ctrl & bus.din[3];

  // ---------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------
  logic rxie_reg, txie_reg, ovr_reg, fe_reg;
  logic ovr_set, fe_set;
  logic irq_int;

  // The interrupt enables are loaded by every control write and cleared only by a hard reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxie_reg <= 1'b0;
      txie_reg <= 1'b0;
    end else if (wr_ctrl) begin
      rxie_reg <= bus.din[7];
      txie_reg <= bus.din[6];
    end
  end

  // Sticky error flags are cleared by a status read, but a new error in the same cycle takes priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      ovr_reg <= 1'b0;
      fe_reg  <= 1'b0;
    end else begin
      if (ovr_set)        ovr_reg <= 1'b1;
      else if (rd_status) ovr_reg <= 1'b0;
      if (fe_set)         fe_reg  <= 1'b1;
      else if (rd_status) fe_reg  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [AW:0]   tx_count_reg;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_count_reg == DEPTH_C);
  assign tx_empty = (tx_count_reg == '0);
  // When the engine pops in the same cycle, a slot is freed, so a push into a full FIFO is still accepted.
  assign tx_push  = wr_data & (~tx_full | tx_pop);

  // TX storage array (no reset, so it maps onto RAM)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus.din;
  end

  // TX FIFO pointers and occupancy; pointer overflow wraps modulo the depth
  always_ff @(posedge clk) begin
    if (clr || tx_flush) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + AW'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + AW'(1);
      tx_count_reg <= tx_count_reg + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
    end
  end

  // ---------------------------------------------------------------
  // TX engine
  // ---------------------------------------------------------------
  state_t        tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          tx_reg, tx_line_next;

  // TX state register; the line output is registered one cycle behind the state
  always_ff @(posedge clk) begin
    if (clr) begin
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_reg       <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_reg       <= tx_line_next;
    end
  end

  // TX next state: fetch a byte, then shift out start, 8 data bits LSB first, and stop
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_pop        = 1'b0;
    tx_line_next  = 1'b1;
    case (tx_state_reg)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_shift_next = tx_mem[tx_rd_ptr_reg];
          tx_cnt_next   = '0;
          tx_state_next = START;
        end
      end
      START: begin
        tx_line_next = 1'b0;
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = DATA;
        end else begin
          tx_cnt_next = tx_cnt_reg + CW'(1);
        end
      end
      DATA: begin
        tx_line_next = tx_shift_reg[0];
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          if (tx_bit_reg == 3'd7) tx_state_next = STOP;
          else                    tx_bit_next   = tx_bit_reg + 3'd1;
        end else begin
          tx_cnt_next = tx_cnt_reg + CW'(1);
        end
      end
      default: begin  // STOP
        tx_line_next = 1'b1;
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          // Chain directly into the next frame so there is no idle gap between frames.
          if (!tx_empty) begin
            tx_pop        = 1'b1;
            tx_shift_next = tx_mem[tx_rd_ptr_reg];
            tx_state_next = START;
          end else begin
            tx_state_next = IDLE;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + CW'(1);
        end
      end
    endcase
  end

  assign tx = tx_reg;

  // ---------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [AW:0]   rx_count_reg;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_byte_ok;
  logic [7:0]    rx_shift_reg;

  assign rx_full  = (rx_count_reg == DEPTH_C);
  assign rx_empty = (rx_count_reg == '0);
  assign rx_pop   = rd_data & ~rx_empty;
  // A CPU pop in the same cycle frees a slot, so a completed byte is still accepted by a full FIFO.
  assign rx_push  = rx_byte_ok & (~rx_full | rx_pop);
  assign ovr_set  = rx_byte_ok & rx_full & ~rx_pop;

  // RX storage array (no reset, so it maps onto RAM)
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_shift_reg;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (clr || rx_flush) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + AW'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + AW'(1);
      rx_count_reg <= rx_count_reg + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
    end
  end

  // ---------------------------------------------------------------
  // RX engine
  // ---------------------------------------------------------------
  logic          rx_s1_reg, rx_s2_reg, rx_s3_reg;
  state_t        rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_next;

  // Two-flop synchroniser, plus a third flop used to detect the falling edge
  always_ff @(posedge clk) begin
    if (clr) begin
      rx_s1_reg <= 1'b1;
      rx_s2_reg <= 1'b1;
      rx_s3_reg <= 1'b1;
    end else begin
      rx_s1_reg <= rx;
      rx_s2_reg <= rx_s1_reg;
      rx_s3_reg <= rx_s2_reg;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (clr) begin
      rx_state_reg <= IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  // RX next state: confirm the start bit at half a bit, then sample each later bit at its centre
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_byte_ok    = 1'b0;
    fe_set        = 1'b0;
    case (rx_state_reg)
      IDLE: begin
        if (rx_s3_reg && !rx_s2_reg) begin
          rx_cnt_next   = '0;
          rx_state_next = START;
        end
      end
      START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next = '0;
          rx_bit_next = '0;
          // A line that is high again at this point is a glitch, not a start bit.
          rx_state_next = rx_s2_reg ? IDLE : DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_s2_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) rx_state_next = STOP;
          else                    rx_bit_next   = rx_bit_reg + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
      default: begin  // STOP
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = IDLE;
          if (rx_s2_reg) rx_byte_ok = 1'b1;
          else           fe_set     = 1'b1;
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Interrupt and read path
  // ---------------------------------------------------------------
  logic [7:0] status, rd_mux, dout_reg;

  assign irq_int = (rxie_reg & (~rx_empty | ovr_reg))
                 | (txie_reg & tx_empty & (tx_state_reg == IDLE));
  assign status  = {irq_int, 1'b0, ovr_reg, fe_reg, tx_full, rx_full, ~tx_full, ~rx_empty};

  // Read data selection; a data read of an empty RX FIFO returns zero
  always_comb begin
    rd_mux = 8'h00;
    case (bus.addr)
      2'd0:    rd_mux = status;
      2'd1:    if (!rx_empty) rd_mux = rx_mem[rx_rd_ptr_reg];
      2'd2:    rd_mux = 8'(rx_count_reg);
      default: rd_mux = 8'(tx_count_reg);
    endcase
  end

  // Read data register: updated only by a read, and holds its value otherwise
  always_ff @(posedge clk) begin
    if (clr)         dout_reg <= 8'h00;
    else if (rd_any) dout_reg <= rd_mux;
  end

  assign bus.dout = dout_reg;
  assign bus.irq  = irq_int;
endmodule

// File: tb/tb_acia_fifo.sv
// Directed testbench for acia_fifo, run with 16 clocks per bit and 4-entry FIFOs.
// All expected values are computed by hand from the register map and the frame timing.
module tb_acia_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  acia_fifo_if bus_if();

  acia_fifo #(
    .CLK_FREQ  (16),
    .SYM_RATE  (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if),
    .rx (rx),
    .tx (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Callers are at a negedge; the access is sampled by the next posedge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.din = d;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    @(negedge clk);
    bus_if.cs = 1'b0;
    d = bus_if.dout;
  endtask

  task automatic wait_rel(input int base, input int rel);
    while (cyc < base + rel) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    logic [9:0] fr;
    logic [7:0] bytes3 [3];
    logic [7:0] rxb [5];
    int base;

    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = 2'd0; bus_if.din = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_tx", tx, 1);
    check("reset_dout", bus_if.dout, 8'h00);
    check("reset_irq", bus_if.irq, 0);
    bus_read(2'd0, rd); check("reset_status", rd, 8'h02);
    bus_read(2'd2, rd); check("reset_rxlvl", rd, 0);
    bus_read(2'd3, rd); check("reset_txlvl", rd, 0);

    // Single frame 0x55: start bit from N+2, 16 clocks per bit
    bus_write(2'd1, 8'h55);
    base = cyc;
    wait_rel(base, 1);   check("tx55_n1_idle", tx, 1);
    wait_rel(base, 2);   check("tx55_n2_start", tx, 0);
    wait_rel(base, 17);  check("tx55_start_end", tx, 0);
    wait_rel(base, 18);  check("tx55_bit0_begin", tx, 1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int k = 1; k < 10; k++) begin
      wait_rel(base, 2 + 16 * k + 8);
      check($sformatf("tx55_bit%0d", k), tx, fr[k]);
    end
    wait_rel(base, 170);
    check("tx55_idle_irq_off", bus_if.irq, 0);

    // Three back-to-back frames: 30 contiguous bit periods
    bytes3[0] = 8'h3C; bytes3[1] = 8'hA1; bytes3[2] = 8'h0F;
    bus_write(2'd1, bytes3[0]);
    base = cyc;
    bus_write(2'd1, bytes3[1]);
    bus_write(2'd1, bytes3[2]);
    bus_read(2'd3, rd); check("tx3_level", rd, 2);
    for (int j = 0; j < 30; j++) begin
      fr = {1'b1, bytes3[j / 10], 1'b0};
      wait_rel(base, 2 + 16 * j + 8);
      check($sformatf("tx3_bit%0d", j), tx, fr[j % 10]);
    end
    wait_rel(base, 2 + 16 * 30 + 8);
    check("tx3_idle_after", tx, 1);

    // RX overrun: 5 frames into a 4-deep FIFO
    rxb[0] = 8'h11; rxb[1] = 8'h22; rxb[2] = 8'h33; rxb[3] = 8'h44; rxb[4] = 8'h55;
    for (int i = 0; i < 5; i++) send_rx(rxb[i], 1'b1);
    bus_read(2'd2, rd); check("ovr_rxlvl", rd, 4);
    bus_read(2'd0, rd); check("ovr_status", rd, 8'h27);
    bus_read(2'd0, rd); check("ovr_status_cleared", rd, 8'h07);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd1, rd); check($sformatf("ovr_data%0d", i), rd, rxb[i]);
    end
    bus_read(2'd2, rd); check("ovr_rxlvl_drained", rd, 0);
    bus_read(2'd1, rd); check("ovr_empty_read", rd, 8'h00);

    // Framing error: stop bit low
    send_rx(8'h5A, 1'b0);
    bus_read(2'd0, rd); check("fe_status", rd, 8'h12);
    bus_read(2'd2, rd); check("fe_rxlvl", rd, 0);
    bus_read(2'd0, rd); check("fe_status_cleared", rd, 8'h02);

    // RX interrupt
    bus_write(2'd0, 8'h80);
    check("irq_before_rx", bus_if.irq, 0);
    send_rx(8'hA5, 1'b1);
    check("irq_after_rx", bus_if.irq, 1);
    bus_read(2'd0, rd); check("irq_status", rd, 8'h83);
    bus_read(2'd1, rd); check("irq_data", rd, 8'hA5);
    check("irq_cleared", bus_if.irq, 0);
    bus_read(2'd1, rd); check("irq_empty_read", rd, 8'h00);

    // Soft reset: clears the FIFO, loads both interrupt enables
    send_rx(8'h3C, 1'b1);
    bus_read(2'd2, rd); check("srst_rxlvl_before", rd, 1);
    bus_write(2'd0, 8'hC3);
    bus_read(2'd2, rd); check("srst_rxlvl_after", rd, 0);
    check("srst_tx_irq", bus_if.irq, 1);
    bus_read(2'd0, rd); check("srst_status", rd, 8'h82);
    bus_write(2'd0, 8'h00);
    check("srst_irq_off", bus_if.irq, 0);

    // TX flush keeps the in-flight frame, then a hard reset aborts it
    bus_write(2'd1, 8'h00);
    base = cyc;
    bus_write(2'd1, 8'h77);
    bus_write(2'd0, 8'h08);
    bus_read(2'd3, rd); check("flush_txlvl", rd, 0);
    wait_rel(base, 2 + 16 * 3 + 8);
    check("flush_frame_alive", tx, 0);
    bus_read(2'd0, rd); check("pre_rst_status", rd, 8'h02);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx_high", tx, 1);
    check("rst_dout", bus_if.dout, 8'h00);
    check("rst_irq", bus_if.irq, 0);
    rst = 1'b0;
    bus_read(2'd2, rd); check("rst_rxlvl", rd, 0);
    bus_read(2'd3, rd); check("rst_txlvl", rd, 0);
    bus_read(2'd0, rd); check("rst_status", rd, 8'h02);
    repeat (40) @(negedge clk);
    check("rst_tx_stays_idle", tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acia_fifo.md
ACIA_FIFO -- requirements
Module: acia_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 32000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SYM_RATE, default 115200, serial bit rate; SYM_CNT = CLK_FREQ/SYM_RATE clocks per bit (integer truncation).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, depth of each of the RX and TX FIFOs; legal values are powers of two from 2 to 128.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cs  input  1  chip select.
REQ-007 SHALL have port we  input  1  write enable, valid when cs is high.
REQ-008 SHALL have port addr  input  2  register select: 0 ctrl/status, 1 data, 2 RX level, 3 TX level.
REQ-009 SHALL have port din  input  8  write data.
REQ-010 SHALL have port dout  output  8  registered read data.
REQ-011 SHALL have port rx  input  1  serial receive, idle high.
REQ-012 SHALL have port tx  output  1  serial transmit, idle high.
REQ-013 SHALL have port irq  output  1  high-true interrupt request.

Function
REQ-014 Control write (cs&we, addr 0) SHALL load rxie=din[7] and txie=din[6]; din[1:0]==2'b11 SHALL also act as a one-cycle soft reset equal to rst, except that rxie/txie take the newly written values.
REQ-015 Control write SHALL flush the RX FIFO when din[2]=1 and the TX FIFO when din[3]=1; the flush completes in that cycle, and an in-flight frame is not aborted.
REQ-016 Data write (cs&we, addr 1) SHALL push din into the TX FIFO; the write is dropped silently if the TX FIFO is full.
REQ-017 Any read (cs&~we) SHALL update dout on the next rising edge; dout SHALL hold its value in all other cycles.
REQ-018 Status read (addr 0) SHALL return {irq, 1'b0, ovr, fe, txfull, rxfull, ~txfull, ~rxempty}.
REQ-019 A status read SHALL clear ovr and fe in the same edge dout is loaded; a set event in that same cycle wins.
REQ-020 Data read (addr 1) SHALL return the RX FIFO head and pop it; if the RX FIFO is empty it SHALL return 8'h00 with no pop.
REQ-021 Reads of addr 2 and addr 3 SHALL return the RX and TX occupancy (0..FIFO_DEPTH), zero-extended to 8 bits.
REQ-022 Serial format SHALL be 8N1, LSB first, each bit SYM_CNT clocks, tx idle high.
REQ-023 The TX engine SHALL have states IDLE, START, DATA, STOP.
REQ-024 In IDLE with the TX FIFO non-empty, the TX engine SHALL pop one byte and drive the start bit from the next edge (write at edge N to an empty FIFO/idle engine -> tx low from edge N+2).
REQ-025 At the end of STOP the TX engine SHALL pop the next byte if the FIFO is non-empty, so back-to-back frames have no idle gap.
REQ-026 The RX engine SHALL detect a falling edge of rx (after a 2-flop synchroniser) and confirm the start bit low at SYM_CNT/2.
REQ-027 The RX engine SHALL sample each data bit and the stop bit at bit centres.
REQ-028 A start bit found high at the confirmation point SHALL return the RX engine to idle with no push.
REQ-029 A stop bit sampled low SHALL set fe and discard the byte.
REQ-030 A byte that completes while the RX FIFO is full SHALL be discarded and set ovr.
REQ-031 When a byte completes in the same cycle as a CPU pop of a full RX FIFO, both SHALL take effect with no ovr.
REQ-032 A CPU push and an engine pop in the same cycle on a full TX FIFO SHALL both take effect.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with occupancy tracked in log2(FIFO_DEPTH)+1 bits.
REQ-034 irq SHALL be combinational: irq = rxie&(~rxempty | ovr) | txie&txempty&(TX engine IDLE).

Reset
REQ-035 On rst (synchronous, active-high) SHALL: dout=8'h00, tx=1, FIFOs empty, both engines IDLE, ovr=fe=0, rxie=txie=0, irq=0.
REQ-036 Reset mid-frame SHALL abort the frame, with tx high on the edge after rst is sampled.

Verification
REQ-037 CLK_FREQ=16, SYM_RATE=1; write 0x55 to addr 1 at edge N -> tx low at N+2, then bits 1,0,1,0,1,0,1,0, then stop high; each bit 16 clocks.
REQ-038 Write 3 bytes back-to-back -> 30 contiguous bit periods with no idle gap; addr 3 reads 2 immediately after the writes.
REQ-039 Drive FIFO_DEPTH+1 frames on rx with no reads -> addr 2 = FIFO_DEPTH, status bit5=1; a status read clears it; data reads return the first FIFO_DEPTH bytes in order.
REQ-040 Frame with stop bit low -> status bit4=1, addr 2 unchanged.
REQ-041 Write ctrl 0x80, receive 0xA5 -> irq=1; read addr 1 -> dout=0xA5, irq=0; another read -> 0x00.
REQ-042 Assert rst mid-frame -> tx=1 next edge, all levels 0, status=8'h02.
